// File: rtl/pwm_audio_rx.sv
// PWM audio receiver: synchronises a 1-bit PWM stream, locks onto its frame
// period and reports each frame's high-time count as a saturated sample.
module pwm_audio_rx #(
  parameter int unsigned PERIOD     = 256,
  parameter int unsigned SAMPLE_W   = 8,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pwm_in,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                locked,
  output logic                frame_err
);

  localparam int unsigned PW = $clog2(PERIOD);
  localparam int unsigned HW = $clog2(PERIOD + 1);
  localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned CW = (HW > SAMPLE_W) ? HW + 1 : SAMPLE_W + 1;

  localparam logic [PW-1:0]       LAST      = PW'(PERIOD - 1);
  localparam logic [GW-1:0]       GOOD_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [SAMPLE_W-1:0] SMAX      = '1;

  typedef enum logic [1:0] {HUNT, TRAIN, LOCK} state_t;

  state_t              state, state_nxt;
  logic                sync_q, s, s_d;
  logic                rise;
  logic [PW-1:0]       period_cnt, period_nxt, period_inc;
  logic [HW-1:0]       high_cnt, high_nxt, high_acc;
  logic [GW-1:0]       good_cnt, good_nxt;
  logic [SAMPLE_W-1:0] sample_nxt, sample_sat;
  logic [CW-1:0]       frame_sum;
  logic                valid_nxt, err_nxt;
  logic                aligned, lock_hit;

  // two-flop synchroniser plus one delay stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
      s      <= 1'b0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= pwm_in;
      s      <= sync_q;
      s_d    <= s;
    end
  end

  assign rise       = s & ~s_d;
  assign aligned    = (period_cnt == '0);
  assign lock_hit   = aligned && (good_cnt == GOOD_LAST);
  assign period_inc = (period_cnt == LAST) ? '0 : period_cnt + PW'(1);
  assign high_acc   = high_cnt + HW'(s);
  assign frame_sum  = CW'(high_cnt) + CW'(s);
  assign sample_sat = (frame_sum > CW'(SMAX)) ? SMAX : frame_sum[SAMPLE_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:    if (rise) state_nxt = TRAIN;
      TRAIN: begin
        if (rise) begin
          if (lock_hit) state_nxt = LOCK;
        end else if (aligned) begin
          state_nxt = HUNT;
        end
      end
      LOCK:    if (rise && !aligned) state_nxt = TRAIN;
      default: state_nxt = HUNT;
    endcase
  end

  // counter and output next values; every rise that (re)starts training anchors at 1
  always_comb begin
    period_nxt = period_cnt;
    high_nxt   = high_cnt;
    good_nxt   = good_cnt;
    sample_nxt = sample;
    valid_nxt  = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      HUNT: begin
        if (rise) begin
          period_nxt = PW'(1);
          high_nxt   = HW'(1);
          good_nxt   = '0;
        end
      end
      TRAIN: begin
        period_nxt = period_inc;
        high_nxt   = high_acc;
        if (rise) begin
          period_nxt = PW'(1);
          high_nxt   = HW'(1);
          if (aligned && !lock_hit) good_nxt = good_cnt + GW'(1);
          else                      good_nxt = '0;
        end else if (aligned) begin
          period_nxt = '0;
          high_nxt   = '0;
          good_nxt   = '0;
        end
      end
      LOCK: begin
        period_nxt = period_inc;
        high_nxt   = high_acc;
        if (rise && !aligned) begin
          period_nxt = PW'(1);
          high_nxt   = HW'(1);
          good_nxt   = '0;
          err_nxt    = 1'b1;
        end else if (period_cnt == LAST) begin
          sample_nxt = sample_sat;
          valid_nxt  = 1'b1;
          high_nxt   = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt   <= '0;
      high_cnt     <= '0;
      good_cnt     <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      period_cnt   <= period_nxt;
      high_cnt     <= high_nxt;
      good_cnt     <= good_nxt;
      sample       <= sample_nxt;
      sample_valid <= valid_nxt;
      locked       <= (state_nxt == LOCK);
      frame_err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_audio_rx.sv
// Scoreboard bench for pwm_audio_rx: a frame-level sync model predicts each
// sample value and its valid cycle; a negedge monitor pops and compares.
module tb_pwm_audio_rx;

  localparam int unsigned P  = 256;
  localparam int unsigned SW = 8;
  localparam int unsigned LC = 4;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b1;
  logic          pwm_in = 1'b0;
  logic [SW-1:0] sample;
  logic          sample_valid;
  logic          locked;
  logic          frame_err;

  always #5 clk = ~clk;

  pwm_audio_rx #(.PERIOD(P), .SAMPLE_W(SW), .LOCK_COUNT(LC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pwm_in       (pwm_in),
    .sample       (sample),
    .sample_valid (sample_valid),
    .locked       (locked),
    .frame_err    (frame_err)
  );

  typedef struct {
    int unsigned val;
    longint      cyc;
  } exp_t;

  exp_t   sb[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_checks++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, req, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: scoreboard pops, lock-rise timestamp, error pulse count
  exp_t   mon_e;
  logic   locked_prev = 1'b0;
  longint lock_cyc    = -1;
  int     err_cnt     = 0;
  int     n_valid     = 0;

  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      n_valid++;
      if (sb.size() == 0) begin
        check("valid_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("sample", 64'(sample), 64'(mon_e.val));
        check("valid_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
    if (frame_err === 1'b1) err_cnt++;
    if (locked === 1'b1 && locked_prev !== 1'b1) lock_cyc = cyc;
    locked_prev = locked;
  end

  // frame-level reference model of the synchroniser
  int     m_state    = 0;  // 0 hunt, 1 train, 2 lock
  int     m_good     = 0;
  int     m_pos      = 0;
  int     m_err      = 0;
  longint m_lock_cyc = -1;
  logic   prev_level = 1'b0;

  task automatic drive_frame(input int len, input int high);
    bit     r;
    longint k;
    exp_t   e;
    @(posedge clk); #1;
    k = cyc;
    r = (high > 0) && !prev_level;
    case (m_state)
      0: if (r) begin m_state = 1; m_good = 0; m_pos = 0; end
      1: begin
        if (r) begin
          if (m_pos == 0) begin
            m_good++;
            if (m_good == LC) begin m_state = 2; m_lock_cyc = k + 3; end
          end else begin
            m_good = 0; m_pos = 0;
          end
        end else if (m_pos == 0) begin
          m_state = 0;
        end
      end
      default: if (r && m_pos != 0) begin m_state = 1; m_good = 0; m_pos = 0; m_err++; end
    endcase
    if (m_state == 2 && m_pos == 0 && len == P) begin
      e.val = (high > 255) ? 255 : high;
      e.cyc = k + P + 2;
      sb.push_back(e);
    end
    m_pos = (m_pos + len) % P;
    for (int i = 0; i < len; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      pwm_in = (i < high);
    end
    prev_level = (high >= len);
  endtask

  // drain pending valids, assert reset between edges and check outputs clear at once
  task automatic do_reset();
    repeat (5) @(posedge clk);
    check("sb_drain", 64'(sb.size()), 64'd0);
    sb.delete();
    pwm_in = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_sample", 64'(sample), 64'd0);
    check("rst_valid", 64'(sample_valid), 64'd0);
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_err", 64'(frame_err), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    m_state = 0; m_good = 0; m_pos = 0; prev_level = 1'b0;
  endtask

  int nv;

  initial begin
    do_reset();

    // steady duty 100: lock after 4 aligned frames, then 4 samples
    for (int i = 0; i < 8; i++) drive_frame(P, 100);
    check("lock_cyc_steady", 64'(lock_cyc), 64'(m_lock_cyc));
    check("locked_steady", 64'(locked), 64'd1);
    check("err_steady", 64'(err_cnt), 64'(m_err));

    // 0% duty frames stay locked, then duty 37 resumes
    for (int i = 0; i < 3; i++) drive_frame(P, 0);
    for (int i = 0; i < 2; i++) drive_frame(P, 37);
    check("locked_zero", 64'(locked), 64'd1);
    check("lock_cyc_zero", 64'(lock_cyc), 64'(m_lock_cyc));

    // 100% duty saturates
    for (int i = 0; i < 2; i++) drive_frame(P, P);
    check("locked_full", 64'(locked), 64'd1);

    // misaligned edge at period_cnt 37 while locked at duty 50
    for (int i = 0; i < 2; i++) drive_frame(P, 50);
    check("sample_pre_glitch", 64'(sample), 64'd50);
    drive_frame(37, 36);
    drive_frame(P, 50);
    check("err_glitch", 64'(err_cnt), 64'(m_err));
    check("locked_glitch", 64'(locked), 64'd0);
    check("sample_held", 64'(sample), 64'd50);
    for (int i = 0; i < 5; i++) drive_frame(P, 50);
    check("locked_relock", 64'(locked), 64'd1);
    check("lock_cyc_relock", 64'(lock_cyc), 64'(m_lock_cyc));
    check("err_relock", 64'(err_cnt), 64'(m_err));
    do_reset();

    // period 255 never locks
    nv = n_valid;
    for (int i = 0; i < 8; i++) drive_frame(P - 1, 100);
    check("locked_p255", 64'(locked), 64'd0);
    check("valid_p255", 64'(n_valid), 64'(nv));
    do_reset();

    // lock, then reset mid-frame; relock needs a full hunt/train again
    for (int i = 0; i < 5; i++) drive_frame(P, 80);
    drive_frame(100, 80);
    check("locked_pre_rst", 64'(locked), 64'd1);
    do_reset();
    for (int i = 0; i < 6; i++) drive_frame(P, 80);
    check("locked_post_rst", 64'(locked), 64'd1);
    check("lock_cyc_post_rst", 64'(lock_cyc), 64'(m_lock_cyc));
    check("err_final", 64'(err_cnt), 64'(m_err));
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_audio_rx.md
Name: pwm_audio_rx

Overview:
- Receive-side counterpart of the PWM audio output.
- Samples a 1-bit PWM stream, locks onto its fixed frame period, and recovers the duty count of each frame as an unsigned sample with a one-cycle valid strobe.
- Used as a loopback/self-test receiver and as the decoder for a second board's audio line.
- Includes a HUNT/TRAIN/LOCK frame synchroniser, so samples are only emitted once frame alignment is proven.

Parameters:
- PERIOD, 256: PWM frame length in clk cycles; legal range >= 4, need not be a power of two.
- SAMPLE_W, 8: width of recovered sample.
- LOCK_COUNT, 4: consecutive correctly spaced rising edges required to lock; legal range >= 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- pwm_in  input  1  PWM stream, asynchronous to clk
- sample  output  SAMPLE_W  last recovered duty count, held between frames
- sample_valid  output  1  one-cycle pulse when sample updates
- locked  output  1  high while state == LOCK
- frame_err  output  1  one-cycle pulse on loss of lock

Behaviour:
- Reset: async on rst_n low. All outputs 0, synchroniser flops 0, state HUNT, all counters 0.
- Input path:
  - 2-flop synchroniser produces s; s_d is s delayed one cycle.
  - rise = s & ~s_d.
  - Pin-to-s latency is 2 cycles.
- Counters:
  - period_cnt is clog2(PERIOD) bits and runs 0..PERIOD-1, wrapping to 0.
  - high_cnt is clog2(PERIOD+1) bits.
  - The cycle with period_cnt == 0 is frame index 0.
- HUNT:
  - period_cnt and high_cnt are idle.
  - On rise: period_cnt <= 1, high_cnt <= 1, good_cnt <= 0, go to TRAIN.
- TRAIN:
  - period_cnt increments every cycle; high_cnt += s.
  - rise with period_cnt == 0: good_cnt++. If good_cnt+1 == LOCK_COUNT, go to LOCK. Then period_cnt <= 1 and high_cnt <= 1.
  - rise with period_cnt != 0: good_cnt <= 0, period_cnt <= 1, high_cnt <= 1, stay in TRAIN (re-anchor on this edge).
  - period_cnt == 0 with no rise: go to HUNT.
  - No samples are emitted in HUNT or TRAIN.
- LOCK:
  - period_cnt free-runs; high_cnt += s each cycle.
  - At period_cnt == PERIOD-1 (frame end):
    - sample <= min(high_cnt + s, 2^SAMPLE_W - 1), saturating.
    - sample_valid pulses the next cycle.
    - high_cnt <= 0.
  - A missing rise at period_cnt == 0 is legal: it covers 0% and 100% duty.
  - rise with period_cnt != 0:
    - frame_err pulses the next cycle; locked drops the next cycle.
    - The partial frame is discarded; sample is unchanged and there is no valid.
    - This rise is treated as the HUNT anchor: go to TRAIN with period_cnt <= 1, high_cnt <= 1, good_cnt <= 0.
- Outputs: sample, sample_valid, locked and frame_err are all registered.
- Lock timing: let the first rise be seen at cycle T.
  - locked asserts at T + LOCK_COUNT*PERIOD + 1.
  - First sample_valid at T + (LOCK_COUNT+1)*PERIOD.
  - After that, sample_valid recurs exactly every PERIOD cycles.
- Simultaneous events:
  - Frame end and rise on the same cycle cannot both occur while locked, since a rise at PERIOD-1 counts as a misaligned rise; the error path wins and no sample is emitted.
  - The lock transition and frame-end accumulation do not conflict.
- Saturation: with PERIOD = 2^SAMPLE_W, 100% duty yields high_cnt = PERIOD, which reports as 2^SAMPLE_W - 1.
- Reset mid-frame: immediate return to reset values; partial frames are never reported.

Test Plan:
- Steady PWM, duty 100/256, frames aligned, 8 frames: locked rises at T+1025; sample_valid every 256 cycles with sample = 100; frame_err stays 0.
- Lock, then hold pwm_in low for 3 frames: sample = 0 on each valid; locked stays 1. Then duty 37 resumes: sample = 37.
- Lock, then hold pwm_in high for 2 frames: sample = 255 (saturated); locked stays 1.
- Locked at duty 50, inject an extra rising edge at period_cnt = 37: frame_err pulse 1 cycle; locked drops; no valid for the broken frame; sample stays 50. Clean frames anchored at the glitch edge relock after 4 further frames.
- Train with frame period 255 instead of 256: good_cnt never reaches 4; locked never asserts; sample_valid never pulses.
- Drop rst_n low asynchronously mid-frame while locked: sample, sample_valid, locked and frame_err are 0 immediately, without waiting for a clk edge. After release, a full HUNT/TRAIN sequence is required before the next valid.
